// File: rtl/norm_clk_generator.sv
// Board-clock divider producing the slow 50%-duty TD4 CPU clock plus a clk_in-domain tick.
// Optional manual single-step (synchronized, debounced button) when CLK_STEP_EN is defined.
module norm_clk_generator #(
    parameter int HALF_SLOW = 25_000_000,
    parameter int HALF_FAST = 2_500_000,
    parameter int DEBOUNCE  = 1_000_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic speed_sel,
`ifdef CLK_STEP_EN
    input  logic step_mode,
    input  logic step_btn,
`endif
    output logic clk_out,
    output logic clk_tick
);

    localparam int MAX_HALF = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
    localparam int MAX_V    = (MAX_HALF > DEBOUNCE) ? MAX_HALF : DEBOUNCE;
    localparam int CNT_W    = $clog2(MAX_V + 1);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] limit;
    logic             toggle;

    assign limit  = speed_sel ? CNT_W'(HALF_FAST - 1) : CNT_W'(HALF_SLOW - 1);
    // >= rather than == so a switch to a shorter rate never overruns the new limit
    assign toggle = (counter >= limit);

`ifdef CLK_STEP_EN
    logic [1:0]       sync_ff;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;

    // db_cnt counts consecutive synchronized samples that disagree with the accepted level
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_ff  <= 2'b00;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_ff <= {sync_ff[0], step_btn};
            if (sync_ff[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt >= CNT_W'(DEBOUNCE - 1)) begin
                db_level <= sync_ff[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            clk_out  <= 1'b0;
            clk_tick <= 1'b0;
`ifdef CLK_STEP_EN
        end else if (step_mode) begin
            counter  <= '0;
            clk_out  <= db_level;
            clk_tick <= db_level && !clk_out;
`endif
        end else if (toggle) begin
            counter  <= '0;
            clk_out  <= ~clk_out;
            clk_tick <= ~clk_out;
        end else begin
            counter  <= counter + CNT_W'(1);
            clk_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_norm_clk_generator.sv
// Scoreboard bench for norm_clk_generator: a phase-length model pushes per-edge expectations,
// a monitor pops and compares them after every clk_in rising edge.
module tb_norm_clk_generator;

    localparam int HS = 5;
    localparam int HF = 2;
    localparam int DB = 3;

    logic clk_in = 1'b0;
    logic reset = 1'b1;
    logic speed_sel = 1'b0;
    logic clk_out, clk_tick;
`ifdef CLK_STEP_EN
    logic step_mode = 1'b0;
    logic step_btn = 1'b0;
`endif

    always #10 clk_in = ~clk_in;

    norm_clk_generator #(.HALF_SLOW(HS), .HALF_FAST(HF), .DEBOUNCE(DB)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .speed_sel(speed_sel),
`ifdef CLK_STEP_EN
        .step_mode(step_mode),
        .step_btn (step_btn),
`endif
        .clk_out  (clk_out),
        .clk_tick (clk_tick)
    );

    typedef struct packed {logic out; logic tick;} exp_t;
    exp_t q[$];

    int   vectors = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    bit   count_en = 1'b0;

    // model: level plus number of edges spent in the current phase
    logic m_out = 1'b0;
    logic m_tick = 1'b0;
    int   m_el = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (count_en && clk_tick === 1'b1) tick_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("clk_out", clk_out, e.out);
            check("clk_tick", clk_tick, e.tick);
        end
    end

    // a phase lasts HALF edges of the currently selected rate; a phase already longer ends now
    task automatic edge_only();
        int half;
        @(posedge clk_in);
        half = speed_sel ? HF : HS;
        if (reset) begin
            m_out = 1'b0; m_tick = 1'b0; m_el = 0;
        end else begin
            m_el++;
            if (m_el >= half) begin
                m_tick = !m_out;
                m_out  = !m_out;
                m_el   = 0;
            end else begin
                m_tick = 1'b0;
            end
        end
        q.push_back('{out: m_out, tick: m_tick});
    endtask

    task automatic cyc(input logic rst, input logic spd);
        @(negedge clk_in);
        reset = rst;
        speed_sel = spd;
        edge_only();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic spd;
        // reset held 100 ns at slow rate, then free-run
        repeat (5) cyc(1'b1, 1'b0);
        repeat (30) cyc(1'b0, 1'b0);

        // 1000 cycles at slow rate contain exactly 100 ticks
        cyc(1'b1, 1'b0);
        tick_cnt = 0;
        count_en = 1'b1;
        repeat (1000) cyc(1'b0, 1'b0);
        #2;
        count_en = 1'b0;
        check("tick_count_1000", tick_cnt, 100);

        // fast rate straight out of reset
        cyc(1'b1, 1'b1);
        repeat (20) cyc(1'b0, 1'b1);

        // rate switch with counter at 4 toggles on the next edge
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        #2;
        check("switch_toggle", clk_out, 1);
        repeat (10) cyc(1'b0, 1'b1);

        // asynchronous reset while clk_out (and clk_tick) are high
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        @(negedge clk_in);
        reset = 1'b1;
        #2;
        check("async_rst_out", clk_out, 0);
        check("async_rst_tick", clk_tick, 0);
        edge_only();
        cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);

        // randomized rate switches and reset pulses
        spd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) spd = ~spd;
            cyc(($urandom_range(39) == 0), spd);
        end

`ifdef CLK_STEP_EN
        cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        repeat (3) @(posedge clk_in);
        #2;
        step_mode = 1'b1;
        repeat (6) @(negedge clk_in);
        check("step_idle", clk_out, 0);
        tick_cnt = 0;
        count_en = 1'b1;
        step_btn = 1'b1;
        repeat (2) @(negedge clk_in);
        step_btn = 1'b0;
        repeat (10) @(negedge clk_in);
        check("step_bounce", clk_out, 0);
        step_btn = 1'b1;
        repeat (10) @(negedge clk_in);
        check("step_press", clk_out, 1);
        step_btn = 1'b0;
        repeat (10) @(negedge clk_in);
        check("step_release", clk_out, 0);
        count_en = 1'b0;
        check("step_ticks", tick_cnt, 1);
        m_out = 1'b0; m_el = 0;
        step_mode = 1'b0;
        edge_only();
        repeat (20) cyc(1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk_in);
        #2;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
